// File: rtl/hit_event_manager.sv
// hit_event_manager: latches raster-rate collision flags across a frame, turns
// them into single-cycle game events at each frame boundary, and owns lives,
// the post-hit invulnerability window and the game-over state.
// Optional feature macro: SCORE_HIT_EN (adds the saturating score output).
module hit_event_manager #(
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned SCORE_PER_POP = 10,
    parameter int unsigned SCORE_W       = 16
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               bubbleHitChar,
    input  logic               arrowHitBubble,
    input  logic               restart,
    output logic               arrowPopPulse,
    output logic               charHitPulse,
    output logic [2:0]         lives,
    output logic               invulnerable,
    output logic               gameOver
`ifdef SCORE_HIT_EN
    ,
    output logic [SCORE_W-1:0] score
`endif
);

    localparam int unsigned LIVES_W = 3;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        S_PLAY      = 2'd0,
        S_INVULN    = 2'd1,
        S_GAME_OVER = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LIVES_W-1:0] r_lives;
    logic [LIVES_W-1:0] w_lives_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_char_l;
    logic               w_char_l_nxt;
    logic               r_arrow_l;
    logic               w_arrow_l_nxt;
    logic               r_char_pulse;
    logic               w_char_pulse_nxt;
    logic               r_pop_pulse;
    logic               w_pop_pulse_nxt;
    logic               r_invuln;
    logic               r_game_over;

    // Next-state, frame latches and event generation
    always_comb begin
        w_state_nxt      = r_state;
        w_lives_nxt      = r_lives;
        w_cnt_nxt        = r_cnt;
        w_char_l_nxt     = r_char_l | bubbleHitChar;
        w_arrow_l_nxt    = r_arrow_l | arrowHitBubble;
        w_char_pulse_nxt = 1'b0;
        w_pop_pulse_nxt  = 1'b0;

        if (restart) begin
            w_state_nxt   = S_PLAY;
            w_lives_nxt   = LIVES_W'(LIVES_INIT);
            w_cnt_nxt     = '0;
            w_char_l_nxt  = 1'b0;
            w_arrow_l_nxt = 1'b0;
        end else if (startOfFrame) begin
            // inputs coincident with the boundary belong to the new frame
            w_char_l_nxt     = bubbleHitChar;
            w_arrow_l_nxt    = arrowHitBubble;
            w_char_pulse_nxt = r_char_l && (r_state == S_PLAY);
            w_pop_pulse_nxt  = r_arrow_l && !r_char_l && (r_state != S_GAME_OVER);

            case (r_state)
                S_PLAY: begin
                    if (r_char_l) begin
                        if (r_lives <= LIVES_W'(1)) begin
                            w_lives_nxt = '0;
                            w_state_nxt = S_GAME_OVER;
                        end else begin
                            w_lives_nxt = r_lives - LIVES_W'(1);
                            w_cnt_nxt   = CNT_W'(INVULN_FRAMES);
                            w_state_nxt = S_INVULN;
                        end
                    end
                end
                S_INVULN: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_PLAY;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_GAME_OVER: begin
                    w_lives_nxt = '0;
                end
                default: begin
                    w_state_nxt = S_PLAY;
                end
            endcase
        end
    end

    // State, latch, counter and registered output updates
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_PLAY;
            r_lives      <= LIVES_W'(LIVES_INIT);
            r_cnt        <= '0;
            r_char_l     <= 1'b0;
            r_arrow_l    <= 1'b0;
            r_char_pulse <= 1'b0;
            r_pop_pulse  <= 1'b0;
            r_invuln     <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lives      <= w_lives_nxt;
            r_cnt        <= w_cnt_nxt;
            r_char_l     <= w_char_l_nxt;
            r_arrow_l    <= w_arrow_l_nxt;
            r_char_pulse <= w_char_pulse_nxt;
            r_pop_pulse  <= w_pop_pulse_nxt;
            r_invuln     <= (w_state_nxt == S_INVULN);
            r_game_over  <= (w_state_nxt == S_GAME_OVER);
        end
    end

    assign arrowPopPulse = r_pop_pulse;
    assign charHitPulse  = r_char_pulse;
    assign lives         = r_lives;
    assign invulnerable  = r_invuln;
    assign gameOver      = r_game_over;

`ifdef SCORE_HIT_EN
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [SCORE_W:0]   w_score_sum;

    // Saturating score accumulation, one increment per pop pulse
    always_comb begin
        w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(SCORE_PER_POP);
        w_score_nxt = r_score;
        if (restart) begin
            w_score_nxt = '0;
        end else if (r_pop_pulse) begin
            w_score_nxt = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
        end
    end

    // Score register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_score <= '0;
        end else begin
            r_score <= w_score_nxt;
        end
    end

    assign score = r_score;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{32'(SCORE_W), 32'(SCORE_PER_POP)};
`endif

endmodule
